cordic_sequencer: RTL and testbench
===================================

# cordic_sequencer

Iterative CORDIC engine controller: accepts one request at a time over a valid/ready handshake and runs ITER shift-add micro-rotations, one per clock. It drives the external arctangent table (4-bit address in, 16-bit angle out) with the iteration index, and returns sin/cos or, optionally, magnitude/angle. It sits between the request source and the arctan table, and owns the x/y/z datapath registers and all sequencing.

## Interface
- ITER, 16: iterations per request; legal 1..16.
- W, 16: I/O data width; all operands are signed Q2.14 (π/4 = 12868).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- angle_in  in  W  rotation angle, radians Q2.14.
- x_in, y_in  in  W  vector operands; only with CORDIC_VECTOR_MODE_EN.
- mode  in  1  0 = rotation, 1 = vectoring; only with CORDIC_VECTOR_MODE_EN.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- cos_out, sin_out  out  W  rotation: cos/sin; vectoring: x (gain-scaled magnitude), y (residual).
- angle_out  out  W  vectoring: atan2(y,x); rotation: residual z.
- rom_addr  out  4  arctan table address (iteration index).
- rom_data  in  16  arctan(2^-rom_addr), Q2.14, combinational on rom_addr.
- busy  out  1  high in ROTATE.

## Operation
- FSM states: IDLE, ROTATE, DONE.
- IDLE: in_ready=1. On in_valid: load registers, set k=0, go to ROTATE.
- Rotation load: x=9949 (K≈0.60725), y=0, z=angle_in clamped to ±25736 (±π/2).
- ROTATE: rom_addr=k. Direction d=+1 if z≥0, else −1 (vectoring: d=+1 if y<0, else −1).
- Per iteration: x'=x−d·(y>>>k), y'=y+d·(x>>>k), z'=z−d·rom_data.
- Arithmetic: registers W+2 bits signed; >>> is arithmetic shift; rom_data zero-extended.
- When k=ITER−1, the iteration still executes, then the FSM goes to DONE; otherwise k increments.
- DONE: out_valid=1; outputs are x, y, z each saturated to W bits and held stable.
- DONE exit: on out_ready, go to IDLE.
- Outputs keep their last values in IDLE; only out_valid drops.
- in_ready=0 in ROTATE and DONE; requests there are not accepted (no queueing).
- rom_addr=0 outside ROTATE.

## Timing
- Reset: FSM IDLE, in_ready=1 (from the first cycle after reset), out_valid=0, busy=0, cos_out=sin_out=angle_out=0, rom_addr=0, k=0.
- Request accepted at edge T. busy=1 during cycles T+1..T+ITER, with iteration k in cycle T+1+k.
- out_valid rises in cycle T+ITER+1; latency is ITER+1 cycles.
- Zero-cycle result accept: if out_ready is high when out_valid rises, IDLE (in_ready=1) follows one cycle later. Throughput is one request per ITER+2 cycles.
- Backpressure: out_ready low holds DONE and outputs indefinitely.
- Reset mid-operation: rst wins over all events; the next cycle is in reset state and the request is discarded.
- in_valid and out_ready high in the same DONE cycle: only the result handshake completes; the request waits for IDLE.

## Configuration
- CORDIC_VECTOR_MODE_EN defined: ports mode, x_in, y_in exist.
  - mode=1 loads x=|x_in|, y=y_in, z=0 (angle_in ignored).
  - Results: cos_out≈1.64676·√(x²+y²) saturated; sin_out≈0; angle_out≈atan(y/|x|).
- CORDIC_VECTOR_MODE_EN undefined: ports absent; rotation only; direction logic has only the z-sign path.

## Structure
- Shared package cordic_pkg holds:
  - FSM state enum (IDLE, ROTATE, DONE).
  - Constant CORDIC_K=9949, ANGLE_MAX=25736, FRAC_BITS=14.
  - Internal width W+2.
- One natural sub-module: cordic_stage (combinational one-iteration shift-add/sub, inputs x, y, z, k, atan, d).
  - The sequencer registers its outputs and owns counter/FSM/handshake.
- Arctan table stays external, reached through rom_addr/rom_data.

## Test plan
- angle_in=0 -> after ITER+1 cycles cos_out=16384±4, sin_out=0±4, angle_out≈0±2.
- angle_in=12868 (π/4) -> cos_out=11585±4, sin_out=11585±4; rom_addr steps 0..15 on busy cycles.
- angle_in=-25736 and angle_in=32767 (clamped to +π/2) -> cos_out=0±4, sin_out=-16384±4 and +16384±4 respectively.
- Backpressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored; release -> in_ready=1 next cycle.
- rst pulsed in cycle T+8 (iteration 7) -> next cycle in_ready=1, out_valid=0, busy=0, outputs 0; a following request completes normally.
- (CORDIC_VECTOR_MODE_EN) mode=1, x_in=8192, y_in=8192 -> angle_out=12868±4, cos_out=19078±8, sin_out=0±4.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer and its stage.
package cordic_pkg;

  localparam int DATA_W    = 16;
  localparam int INT_W     = DATA_W + 2;
  localparam int FRAC_BITS = 14;
  localparam int CORDIC_K  = 9949;
  localparam int ANGLE_MAX = 25736;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation: shift-add/sub on x/y, table step on z.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int IW = INT_W
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [IW-1:0] z,
  input  logic        [3:0]    k,
  input  logic        [15:0]   atan,
  input  logic                 d,
  output logic signed [IW-1:0] x_next,
  output logic signed [IW-1:0] y_next,
  output logic signed [IW-1:0] z_next
);

  logic signed [IW-1:0] xs_s;
  logic signed [IW-1:0] ys_s;
  logic signed [IW-1:0] at_s;

  // d=1 means a +1 rotation step; the table angle is an unsigned magnitude.
  always_comb begin
    xs_s = x >>> k;
    ys_s = y >>> k;
    at_s = {{(IW-16){1'b0}}, atan};
    if (d) begin
      x_next = x - ys_s;
      y_next = y + xs_s;
      z_next = z - at_s;
    end else begin
      x_next = x + ys_s;
      y_next = y - xs_s;
      z_next = z + at_s;
    end
  end

endmodule

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC controller: one request at a time, ITER micro-rotations against an
// external arctan table. Vectoring (mode/x_in/y_in) is built with CORDIC_VECTOR_MODE_EN.
module cordic_sequencer
  import cordic_pkg::*;
#(
  parameter int ITER = 16,
  parameter int W    = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] angle_in,
`ifdef CORDIC_VECTOR_MODE_EN
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cos_out,
  output logic [W-1:0] sin_out,
  output logic [W-1:0] angle_out,
  output logic [3:0]   rom_addr,
  input  logic [15:0]  rom_data,
  output logic         busy
);

  localparam int                   IW     = W + 2;
  localparam logic [3:0]           LAST_K = 4'(ITER - 1);
  localparam logic signed [IW-1:0] AMAX   = IW'(ANGLE_MAX);
  localparam logic signed [IW-1:0] GAIN0  = IW'(CORDIC_K);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [3:0]           k_r;
  logic signed [IW-1:0] x_r, y_r, z_r;
  logic signed [IW-1:0] x_nxt_s, y_nxt_s, z_nxt_s;
  logic signed [IW-1:0] angle_ext_s, clamp_s;
  logic signed [IW-1:0] ld_x_s, ld_y_s, ld_z_s;
  logic [W-1:0]         cos_r, sin_r, angle_r;
  logic                 d_s;
  logic                 accept_s;
  logic                 last_s;
`ifdef CORDIC_VECTOR_MODE_EN
  logic                 mode_r;
  logic signed [IW-1:0] xv_s;
`endif

  // Clip an internal value to the signed W-bit output range.
  function automatic logic [W-1:0] sat_w(input logic signed [IW-1:0] v);
    logic [W-1:0] r;
    if (!v[IW-1] && (v[IW-2:W-1] != '0)) begin
      r = {1'b0, {(W-1){1'b1}}};
    end else if (v[IW-1] && (v[IW-2:W-1] != '1)) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = v[W-1:0];
    end
    return r;
  endfunction

  assign accept_s = (state_r == IDLE) && in_valid;
  assign last_s   = (state_r == ROTATE) && (k_r == LAST_K);

  // Operand load values; rotation requests are limited to +-pi/2 so CORDIC converges.
  always_comb begin
    angle_ext_s = {{2{angle_in[W-1]}}, angle_in};
    if (angle_ext_s > AMAX) begin
      clamp_s = AMAX;
    end else if (angle_ext_s < -AMAX) begin
      clamp_s = -AMAX;
    end else begin
      clamp_s = angle_ext_s;
    end
`ifdef CORDIC_VECTOR_MODE_EN
    xv_s = {{2{x_in[W-1]}}, x_in};
    if (mode) begin
      if (xv_s[IW-1]) begin
        ld_x_s = -xv_s;
      end else begin
        ld_x_s = xv_s;
      end
      ld_y_s = {{2{y_in[W-1]}}, y_in};
      ld_z_s = '0;
    end else begin
      ld_x_s = GAIN0;
      ld_y_s = '0;
      ld_z_s = clamp_s;
    end
`else
    ld_x_s = GAIN0;
    ld_y_s = '0;
    ld_z_s = clamp_s;
`endif
  end

  // Rotation steers z toward zero; vectoring steers y toward zero.
  always_comb begin
`ifdef CORDIC_VECTOR_MODE_EN
    if (mode_r) begin
      d_s = y_r[IW-1];
    end else begin
      d_s = ~z_r[IW-1];
    end
`else
    d_s = ~z_r[IW-1];
`endif
  end

  cordic_stage #(.IW(IW)) u_stage (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .k      (k_r),
    .atan   (rom_data),
    .d      (d_s),
    .x_next (x_nxt_s),
    .y_next (y_nxt_s),
    .z_next (z_nxt_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a request waits in DONE until the result handshake frees IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = ROTATE;
        else          state_nxt_s = IDLE;
      end
      ROTATE: begin
        if (k_r == LAST_K) state_nxt_s = DONE;
        else               state_nxt_s = ROTATE;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    rom_addr  = 4'd0;
    case (state_r)
      IDLE:    in_ready = 1'b1;
      ROTATE: begin
        busy     = 1'b1;
        rom_addr = k_r;
      end
      DONE:    out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath registers: load on accept, one micro-rotation per ROTATE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
      z_r <= '0;
      k_r <= 4'd0;
    end else if (accept_s) begin
      x_r <= ld_x_s;
      y_r <= ld_y_s;
      z_r <= ld_z_s;
      k_r <= 4'd0;
    end else if (state_r == ROTATE) begin
      x_r <= x_nxt_s;
      y_r <= y_nxt_s;
      z_r <= z_nxt_s;
      k_r <= last_s ? 4'd0 : k_r + 4'd1;
    end
  end

`ifdef CORDIC_VECTOR_MODE_EN
  // Mode is captured with the operands and held for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= 1'b0;
    end else if (accept_s) begin
      mode_r <= mode;
    end
  end
`endif

  // Result registers capture the final iteration and hold through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cos_r   <= '0;
      sin_r   <= '0;
      angle_r <= '0;
    end else if (last_s) begin
      cos_r   <= sat_w(x_nxt_s);
      sin_r   <= sat_w(y_nxt_s);
      angle_r <= sat_w(z_nxt_s);
    end
  end

  assign cos_out   = cos_r;
  assign sin_out   = sin_r;
  assign angle_out = angle_r;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: real-math scoreboard with tolerances,
// handshake/latency, backpressure and reset checks.
module tb_cordic_sequencer;

  localparam int ITER = 16;
  localparam int W    = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] angle_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] cos_out, sin_out, angle_out;
  logic [3:0]   rom_addr;
  logic [15:0]  rom_data;
  logic         busy;
`ifdef CORDIC_VECTOR_MODE_EN
  logic [W-1:0] x_in, y_in;
  logic         mode;
`endif

  logic [15:0] rom_tbl [16];
  assign rom_data = rom_tbl[rom_addr];

  typedef struct {
    int c; int s; int a;
    int tc; int ts; int ta;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cordic_sequencer #(.ITER(ITER), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
`ifdef CORDIC_VECTOR_MODE_EN
    .x_in      (x_in),
    .y_in      (y_in),
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .angle_out (angle_out),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  function automatic int sv(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic push_rot(input int a);
    exp_t e;
    int   ac;
    real  th;
    ac = (a > 25736) ? 25736 : ((a < -25736) ? -25736 : a);
    th = real'(ac) / 16384.0;
    e.c = int'(16384.0 * $cos(th));
    e.s = int'(16384.0 * $sin(th));
    e.a = 0;
    e.tc = 4; e.ts = 4; e.ta = 2;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] a, output logic ok);
    int n;
    n = 0;
    angle_in = a;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; angle_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b rom_addr=%0d expected 1 0 0 0",
               in_ready, out_valid, busy, rom_addr);
    end
    checks++;
    if (cos_out !== 16'd0 || sin_out !== 16'd0 || angle_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_data cos=%h sin=%h angle=%h expected 0 0 0", cos_out, sin_out, angle_out);
    end
  endtask

  task automatic test_rotation();
    int   angs [6] = '{0, 12868, -25736, 32767, -12868, 7000};
    exp_t e;
    logic ok;
    for (int i = 0; i < 6; i++) begin
      push_rot(angs[i]);
      issue(16'(angs[i]), ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL rot_accept angle=%0d in_ready=%b expected 1", angs[i], ok);
      end
      for (int k = 0; k < ITER; k++) begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || rom_addr !== 4'(k)) begin
          errors++;
          $display("FAIL rot_iter angle=%0d k=%0d busy=%b out_valid=%b rom_addr=%0d expected 1 0 %0d",
                   angs[i], k, busy, out_valid, rom_addr, k);
        end
        @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rot_latency angle=%0d out_valid=%b busy=%b expected 1 0", angs[i], out_valid, busy);
      end
      e = sb_q.pop_front();
      checks++;
      if (absd(sv(cos_out), e.c) > e.tc) begin
        errors++;
        $display("FAIL rot_cos angle=%0d got %0d expected %0d+-%0d", angs[i], sv(cos_out), e.c, e.tc);
      end
      checks++;
      if (absd(sv(sin_out), e.s) > e.ts) begin
        errors++;
        $display("FAIL rot_sin angle=%0d got %0d expected %0d+-%0d", angs[i], sv(sin_out), e.s, e.ts);
      end
      checks++;
      if (absd(sv(angle_out), e.a) > e.ta) begin
        errors++;
        $display("FAIL rot_z angle=%0d got %0d expected %0d+-%0d", angs[i], sv(angle_out), e.a, e.ta);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          absd(sv(cos_out), e.c) > e.tc || absd(sv(sin_out), e.s) > e.ts) begin
        errors++;
        $display("FAIL rot_idle angle=%0d in_ready=%b out_valid=%b busy=%b cos=%0d sin=%0d expected 1 0 0 %0d %0d",
                 angs[i], in_ready, out_valid, busy, sv(cos_out), sv(sin_out), e.c, e.s);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t         e;
    logic         ok;
    int           n;
    logic [W-1:0] hc, hs, ha;
    out_ready = 1'b0;
    push_rot(12868);
    issue(16'd12868, ok);
    wait_valid(n);
    checks++;
    if (ok !== 1'b1 || n != ITER) begin
      errors++;
      $display("FAIL bp_latency accepted=%b cycles=%0d expected 1 %0d", ok, n, ITER);
    end
    e = sb_q.pop_front();
    checks++;
    if (absd(sv(cos_out), e.c) > e.tc || absd(sv(sin_out), e.s) > e.ts) begin
      errors++;
      $display("FAIL bp_result cos=%0d sin=%0d expected %0d %0d +-4", sv(cos_out), sv(sin_out), e.c, e.s);
    end
    hc = cos_out; hs = sin_out; ha = angle_out;
    in_valid = 1'b1;
    angle_in = 16'd3000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
          cos_out !== hc || sin_out !== hs || angle_out !== ha) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b busy=%b cos=%h sin=%h expected 1 0 0 %h %h",
                 i, out_valid, in_ready, busy, cos_out, sin_out, hc, hs);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    push_rot(-7000);
    push_rot(20000);
    out_ready = 1'b1;
    angle_in = 16'(-7000);
    in_valid = 1'b1;
    wait_valid(n);
    checks++;
    if (n != ITER + 1) begin
      errors++;
      $display("FAIL b2b_latency got %0d cycles expected %0d", n, ITER + 1);
    end
    e = sb_q.pop_front();
    checks++;
    if (absd(sv(cos_out), e.c) > e.tc || absd(sv(sin_out), e.s) > e.ts) begin
      errors++;
      $display("FAIL b2b_first cos=%0d sin=%0d expected %0d %0d +-4", sv(cos_out), sv(sin_out), e.c, e.s);
    end
    angle_in = 16'd20000;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != ITER + 2) begin
      errors++;
      $display("FAIL b2b_throughput got %0d cycles expected %0d", n, ITER + 2);
    end
    e = sb_q.pop_front();
    checks++;
    if (absd(sv(cos_out), e.c) > e.tc || absd(sv(sin_out), e.s) > e.ts) begin
      errors++;
      $display("FAIL b2b_second cos=%0d sin=%0d expected %0d %0d +-4", sv(cos_out), sv(sin_out), e.c, e.s);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic ok;
    int   n;
    issue(16'd12868, ok);
    repeat (7) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || busy !== 1'b1 || rom_addr !== 4'd7) begin
      errors++;
      $display("FAIL rstmid_iter7 accepted=%b busy=%b rom_addr=%0d expected 1 1 7", ok, busy, rom_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'd0 ||
        cos_out !== 16'd0 || sin_out !== 16'd0 || angle_out !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_state in_ready=%b out_valid=%b busy=%b rom_addr=%0d cos=%h sin=%h angle=%h expected 1 0 0 0 0 0 0",
               in_ready, out_valid, busy, rom_addr, cos_out, sin_out, angle_out);
    end
    push_rot(0);
    issue(16'd0, ok);
    wait_valid(n);
    checks++;
    if (ok !== 1'b1 || n != ITER) begin
      errors++;
      $display("FAIL rstmid_after accepted=%b cycles=%0d expected 1 %0d", ok, n, ITER);
    end
    e = sb_q.pop_front();
    checks++;
    if (absd(sv(cos_out), e.c) > e.tc || absd(sv(sin_out), e.s) > e.ts || absd(sv(angle_out), e.a) > e.ta) begin
      errors++;
      $display("FAIL rstmid_result cos=%0d sin=%0d z=%0d expected %0d %0d %0d",
               sv(cos_out), sv(sin_out), sv(angle_out), e.c, e.s, e.a);
    end
    @(negedge clk);
  endtask

`ifdef CORDIC_VECTOR_MODE_EN
  task automatic test_vector();
    int   xs [2] = '{8192, -10000};
    int   ys [2] = '{8192, -6000};
    exp_t e;
    logic ok;
    int   n, ax;
    real  mag;
    for (int i = 0; i < 2; i++) begin
      ax = (xs[i] < 0) ? -xs[i] : xs[i];
      mag = 1.64676 * $sqrt(real'(xs[i]) * real'(xs[i]) + real'(ys[i]) * real'(ys[i]));
      e.c = (mag > 32767.0) ? 32767 : int'(mag);
      e.s = 0;
      e.a = int'($atan2(real'(ys[i]), real'(ax)) * 16384.0);
      e.tc = 8; e.ts = 4; e.ta = 4;
      sb_q.push_back(e);
      mode = 1'b1; x_in = 16'(xs[i]); y_in = 16'(ys[i]);
      issue(16'd5000, ok);
      mode = 1'b0;
      wait_valid(n);
      e = sb_q.pop_front();
      checks++;
      if (ok !== 1'b1 || n != ITER || absd(sv(cos_out), e.c) > e.tc ||
          absd(sv(sin_out), e.s) > e.ts || absd(sv(angle_out), e.a) > e.ta) begin
        errors++;
        $display("FAIL vector x=%0d y=%0d mag=%0d y=%0d ang=%0d cycles=%0d expected %0d %0d %0d %0d",
                 xs[i], ys[i], sv(cos_out), sv(sin_out), sv(angle_out), n, e.c, e.s, e.a, ITER);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_tbl[i] = 16'(int'($atan(1.0 / (2.0 ** i)) * 16384.0));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; angle_in = '0;
`ifdef CORDIC_VECTOR_MODE_EN
    mode = 1'b0; x_in = '0; y_in = '0;
`endif
    @(negedge clk);
    test_reset();
    test_rotation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef CORDIC_VECTOR_MODE_EN
    test_vector();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
